// File: rtl/coin_start_sequencer_if.sv
// coin_start_sequencer_if: frame tick, player requests and the coin/start lines to the core
interface coin_start_sequencer_if;
    logic vblank;
    logic req_start1;
    logic req_start2;
    logic req_coin;
    logic coin;
    logic start1;
    logic start2;
    logic busy;
    modport master(output vblank, req_start1, req_start2, req_coin, input coin, start1, start2, busy);
    modport slave(input vblank, req_start1, req_start2, req_coin, output coin, start1, start2, busy);
endinterface

// File: rtl/coin_start_sequencer.sv
// coin_start_sequencer: turns a player start request into a frame-timed coin-then-start pulse train
module coin_start_sequencer #(
    parameter int COIN_FRAMES  = 4,
    parameter int GAP_FRAMES   = 8,
    parameter int START_FRAMES = 4,
    parameter int COINS_2P     = 2
) (
    input logic clk,
    input logic reset,
    coin_start_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] COIN_ON  = 3'd1;
    localparam logic [2:0] COIN_GAP = 3'd2;
    localparam logic [2:0] START_ON = 3'd3;
    localparam logic [2:0] RELEASE  = 3'd4;
    logic [2:0] state, nxt;
    logic [3:0] cnt, lim;
    logic [1:0] coins, coins_n;
    logic p2, p2_n;
    logic vb_q, r1_q, r2_q;
    logic tick, e1, e2, done;
    logic coin_r, start1_r, start2_r, busy_r;
    assign tick = bus.vblank & ~vb_q;
    assign e1 = bus.req_start1 & ~r1_q;
    assign e2 = bus.req_start2 & ~r2_q;
    assign lim = state == COIN_ON ? 4'(COIN_FRAMES) : state == COIN_GAP ? 4'(GAP_FRAMES) : 4'(START_FRAMES);
    // the tick that brings the frame count up to the limit is the exit tick
    assign done = tick && (cnt + 4'd1 == lim);
    always_comb begin
        nxt = state;
        coins_n = coins;
        p2_n = p2;
        case (state)
            IDLE: begin
                if (e2) begin
                    p2_n = 1'b1;
                    coins_n = 2'(COINS_2P);
                    nxt = COIN_ON;
                end else if (e1) begin
                    p2_n = 1'b0;
                    coins_n = 2'd1;
                    nxt = COIN_ON;
                end
            end
            COIN_ON: begin
                if (done) begin
                    coins_n = coins - 2'd1;
                    nxt = COIN_GAP;
                end
            end
            COIN_GAP: nxt = done ? (coins != 2'd0 ? COIN_ON : START_ON) : state;
            START_ON: nxt = done ? RELEASE : state;
            RELEASE:  nxt = (!bus.req_start1 && !bus.req_start2) ? IDLE : state;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            coins <= 2'd0;
            p2 <= 1'b0;
            vb_q <= 1'b0;
            r1_q <= 1'b0;
            r2_q <= 1'b0;
            coin_r <= 1'b0;
            start1_r <= 1'b0;
            start2_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= (nxt != state) ? 4'd0 : cnt + 4'(tick);
            coins <= coins_n;
            p2 <= p2_n;
            vb_q <= bus.vblank;
            r1_q <= bus.req_start1;
            r2_q <= bus.req_start2;
            coin_r <= (nxt == COIN_ON) || (state == IDLE && bus.req_coin);
            start1_r <= (nxt == START_ON) && !p2_n;
            start2_r <= (nxt == START_ON) && p2_n;
            busy_r <= nxt != IDLE;
        end
    end
    assign bus.coin = coin_r;
    assign bus.start1 = start1_r;
    assign bus.start2 = start2_r;
    assign bus.busy = busy_r;
endmodule
